// File: rtl/cla_slice_sequencer.sv
// rtl/cla_slice_sequencer.sv - multi-cycle add/subtract reusing one 4-bit CLA slice
// Sequences WIDTH/SLICE slice passes with a registered inter-slice carry.
module cla_slice_sequencer #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             mode,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V
);

  localparam int N     = WIDTH / SLICE;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  if (WIDTH % SLICE != 0) begin : g_bad_slice
    $error("cla_slice_sequencer: WIDTH must be a multiple of SLICE");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d, v_q, v_d;
  logic             ready_q, ready_d, busy_q, busy_d, done_q, done_d;

  logic [SLICE-1:0] sl_a, sl_b, sl_g, sl_p, sl_sum;
  logic [SLICE:0]   sl_c;
  int               base;

  // Combinational CLA slice over the bits selected by idx_q.
  always_comb begin
    base = int'(idx_q) * SLICE;
    sl_a = op_a_q[base +: SLICE];
    sl_b = op_b_q[base +: SLICE];
    sl_g = sl_a & sl_b;
    sl_p = sl_a | sl_b;
    sl_c = '0;
    sl_c[0] = carry_q;
    for (int i = 0; i < SLICE; i++) begin
      sl_c[i+1] = sl_g[i] | (sl_p[i] & sl_c[i]);
    end
    sl_sum = sl_a ^ sl_b ^ sl_c[SLICE-1:0];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    s_d     = s_q;
    cout_d  = cout_q;
    v_d     = v_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_a_d  = A;
          op_b_d  = mode ? ~B : B;
          carry_d = mode ? 1'b1 : Cin;
          idx_d   = '0;
          state_d = RUN;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        s_d[base +: SLICE] = sl_sum;
        carry_d = sl_c[SLICE];
        if (idx_q == LAST) begin
          cout_d  = sl_c[SLICE];
          v_d     = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) && (sl_sum[SLICE-1] != op_a_q[WIDTH-1]);
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign S     = s_q;
  assign Cout  = cout_q;
  assign V     = v_q;

endmodule

// File: doc/cla_slice_sequencer.md
Name: cla_slice_sequencer

Overview:
Multi-cycle 32-bit add/subtract unit that reuses a single 4-bit carry-lookahead slice over WIDTH/SLICE cycles, registering the inter-slice carry between cycles. It sits between a requesting controller and the adder datapath. It trades latency for area compared with the full-width CLA, and presents a start/ready/done handshake.
- The 4-bit slice is combinational and lives inside this block.
- The slice uses G = A&B, P = A|B and the per-bit ripple-of-lookahead carry equations.

Parameters:
WIDTH, 32, operand/result width; must be an integer multiple of SLICE (elaboration error otherwise).
SLICE, 4, bits processed per cycle by the internal CLA slice.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous, active-low reset.
start  input  1  request; accepted only on a cycle where start=1 and ready=1.
A  input  WIDTH  operand A; sampled at acceptance.
B  input  WIDTH  operand B; sampled at acceptance.
Cin  input  1  carry-in for add; ignored when mode=1.
mode  input  1  0 = add (A+B+Cin), 1 = subtract (A+~B+1); sampled at acceptance.
ready  output  1  high when state==IDLE.
busy  output  1  high in RUN and DONE.
done  output  1  one-cycle pulse; results are valid from this cycle onward.
S  output  WIDTH  result.
Cout  output  1  carry out of the MSB. For subtract, 1 = no borrow.
V  output  1  signed overflow.

Behaviour:
- Clocking and reset:
  - Single clock domain. rst_n is sampled on the rising clk edge.
  - Reset state: IDLE, S=0, Cout=0, V=0, done=0, busy=0, slice index=0, carry register=0. ready=1 follows from IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - On start=1: capture A into opA; capture Beff = mode ? ~B : B into opB; set the carry register to mode ? 1 : Cin; set idx=0; go to RUN.
  - S/Cout/V keep their previous values until overwritten.
- RUN, one slice per cycle:
  - Slice k = idx covers bits [k*SLICE +: SLICE].
  - The slice computes sum and carry-out from opA, opB and the carry register.
  - At each edge: write the slice sum into S[k*SLICE +: SLICE], load the slice carry-out into the carry register, and increment idx.
  - On the edge that commits slice WIDTH/SLICE-1: Cout := slice carry-out, V := (opA[MSB]==opB[MSB]) && (S_new[MSB]!=opA[MSB]), state := DONE.
  - ready=0 throughout RUN.
- DONE:
  - done=1 and busy=1 for exactly one cycle, then IDLE unconditionally.
  - start is ignored in DONE.
- Latency:
  - Acceptance edge is E0; slices commit at E1..E(N) with N=WIDTH/SLICE (8 by default).
  - done is high during the cycle after E(N), i.e. N+1 cycles after the accepting cycle (9 by default).
  - The earliest next acceptance is the cycle after done (back-to-back throughput of one op per N+2 cycles).
- Holding and input stability:
  - S, Cout and V hold after done until the next op's RUN cycles overwrite them.
  - Partial S bits are visible during RUN. Consumers must sample only on done.
  - Changes on A/B/Cin/mode/start outside the acceptance cycle have no effect.
- Reset mid-operation: any cycle with rst_n=0 aborts immediately to reset state. No done pulse is produced for the aborted op.
- Counter width: the idx counter is $clog2(WIDTH/SLICE) bits, minimum 1. It never wraps within an op, because the last slice transitions the FSM out of RUN.

Test Plan:
1. Add, in-slice carry propagation: A=0x0000FFFF, B=0x00000001, Cin=0, mode=0 -> S=0x00010000, Cout=0, V=0; done exactly 9 cycles after the accepting cycle; ready low for cycles 1..9.
2. Full carry chain: A=0xFFFFFFFF, B=0x00000001, Cin=0, mode=0 -> S=0x00000000, Cout=1, V=0. Then A=0x00000001, B=0x00000001, Cin=1 -> S=0x00000003, Cout=0.
3. Subtract with borrow: A=0x00000005, B=0x00000007, mode=1, Cin=1 (must be ignored) -> S=0xFFFFFFFE, Cout=0, V=0. Then A=7, B=5 -> S=0x00000002, Cout=1.
4. Overflow, both signs:
   - A=0x7FFFFFFF, B=0x00000001, add -> S=0x80000000, V=1, Cout=0.
   - A=0x80000000, B=0x00000001, subtract -> S=0x7FFFFFFF, V=1, Cout=1.
5. Handshake:
   - Hold start=1 continuously with changing operands -> only the values present on ready=1 cycles are accepted; start during RUN/DONE is ignored.
   - The second op is accepted the cycle after done, and its results are correct.
6. Reset mid-op: deassert rst_n for one cycle while idx=4 -> next cycle S=0, Cout=0, V=0, done=0, busy=0, ready=1, and no done pulse appears. A fresh op (0x12345678 + 0x11111111) then completes with S=0x23456789.
